pc_unit: RTL and testbench

- Registered program-counter unit for the RV32 core.
- Selects the next fetch address from sequential step, branch, jump and trap sources.
- Holds the PC during pipeline stalls without losing redirects that arrive while stalled.
- Flags misaligned control-transfer targets for the trap controller.
- Replaces the purely combinational next-PC selector; sits between the fetch stage and the branch/jump/trap logic.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_redirect_arb.sv | 50 +++++
 rtl/pc_unit.sv | 127 ++++++++++++
 tb/tb_pc_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared state/source encodings and step constants for the PC unit.
package pc_pkg;

    // Control states of the PC unit.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;

    // Redirect sources; the numeric order is the fixed priority order.
    typedef enum logic [1:0] {
        SRC_SEQ    = 2'd0,
        SRC_BRANCH = 2'd1,
        SRC_JUMP   = 2'd2,
        SRC_TRAP   = 2'd3
    } redirect_src_e;

    localparam int unsigned PC_STEP32 = 4;
    localparam int unsigned PC_STEP16 = 2;

endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: combinational priority encoder for PC redirects.
// Picks trap > jump > branch, forms the target and flags a misaligned
// jump/branch target. With PC_COMPRESSED_EN defined only bit 0 is
// checked/forced; otherwise the low two bits are.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic            trapped,
    input  logic [XLEN-1:0] trap_target,
    output redirect_src_e   src,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

`ifdef PC_COMPRESSED_EN
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(1);
`else
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(3);
`endif

    // Select the highest-priority redirect and check its alignment.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        src        = SRC_SEQ;
        target     = '0;
        misaligned = 1'b0;
        if (trapped) begin
            src    = SRC_TRAP;
            target = trap_target & ~LOW_MASK;
        end else if (jump) begin
            src    = SRC_JUMP;
            target = jump_target;
        end else if (branch_taken) begin
            src    = SRC_BRANCH;
            target = pc + imm;
        end
        // Trap vectors are forced aligned above, so only jump/branch can fault.
        if (src == SRC_JUMP || src == SRC_BRANCH) begin
            misaligned = |(target & LOW_MASK);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: registered program counter with stall-time redirect capture.
// Optional feature: define PC_COMPRESSED_EN to add the inst_len16 port
// (2-byte sequential step) and relax alignment to 2 bytes.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_stall,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic            trapped,
    input  logic [XLEN-1:0] trap_target,
`ifdef PC_COMPRESSED_EN
    input  logic            inst_len16,
`endif
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            pc_valid,
    output logic            pending_valid,
    output logic            misaligned,
    output logic [XLEN-1:0] misaligned_addr
);

    pc_state_e       state;
    redirect_src_e   arb_src;
    logic [XLEN-1:0] arb_target;
    logic            arb_misaligned;
    redirect_src_e   pending_src;
    logic [XLEN-1:0] pending_target;
    logic [XLEN-1:0] step;
    logic            take_new;
    logic            accept_new;
    logic            flag_mis;

`ifdef PC_COMPRESSED_EN
    assign step = inst_len16 ? XLEN'(PC_STEP16) : XLEN'(PC_STEP32);
`else
    assign step = XLEN'(PC_STEP32);
`endif

    pc_redirect_arb #(.XLEN(XLEN)) u_arb (
        .pc           (pc),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .imm          (imm),
        .trapped      (trapped),
        .trap_target  (trap_target),
        .src          (arb_src),
        .target       (arb_target),
        .misaligned   (arb_misaligned)
    );

    // Decide whether this cycle's redirect is used and form the next PC.
    always_comb begin
        take_new = 1'b0;
        next_pc  = pc;
        case (state)
            RUN:     take_new = (arb_src != SRC_SEQ);
            // In HOLD a new redirect wins only at equal or higher priority.
            HOLD:    take_new = (arb_src != SRC_SEQ) && (arb_src >= pending_src);
            default: take_new = 1'b0;
        endcase
        accept_new = take_new && !arb_misaligned;
        flag_mis   = take_new && arb_misaligned && !reset;

        if (reset) begin
            next_pc = RESET_VECTOR;
        end else if (state == BOOT || pc_stall) begin
            next_pc = pc;
        end else if (accept_new) begin
            next_pc = arb_target;
        end else if (flag_mis) begin
            next_pc = pc;
        end else if (state == HOLD) begin
            next_pc = pending_target;
        end else begin
            next_pc = pc + step;
        end
    end

    // State, PC, pending-redirect and misalignment registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state           <= BOOT;
            pc              <= RESET_VECTOR;
            pc_valid        <= 1'b0;
            pending_valid   <= 1'b0;
            pending_src     <= SRC_SEQ;
            pending_target  <= '0;
            misaligned      <= 1'b0;
            misaligned_addr <= '0;
        end else begin
            pc              <= next_pc;
            misaligned      <= flag_mis;
            misaligned_addr <= flag_mis ? arb_target : '0;
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN, HOLD: begin
                    if (pc_stall) begin
                        if (accept_new) begin
                            pending_valid  <= 1'b1;
                            pending_src    <= arb_src;
                            pending_target <= arb_target;
                            state          <= HOLD;
                        end
                    end else begin
                        pending_valid <= 1'b0;
                        state         <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed plus randomized test of pc_unit against a
// rule-level reference model.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0200;
`ifdef PC_COMPRESSED_EN
    localparam logic [31:0] LOW_MASK = 32'h1;
`else
    localparam logic [31:0] LOW_MASK = 32'h3;
`endif

    logic        clk;
    logic        reset;
    logic        pc_stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] imm;
    logic        trapped;
    logic [31:0] trap_target;
`ifdef PC_COMPRESSED_EN
    logic        inst_len16;
`endif
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pc_valid;
    logic        pending_valid;
    logic        misaligned;
    logic [31:0] misaligned_addr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        pend;
        int          pprio;
        logic [31:0] ptgt;
        logic        mis;
        logic [31:0] mis_addr;
    } m_state_t;

    m_state_t m = '{pc: 32'h0, valid: 1'b0, pend: 1'b0, pprio: 0,
                    ptgt: 32'h0, mis: 1'b0, mis_addr: 32'h0};

    pc_unit #(.XLEN(32), .RESET_VECTOR(RV)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_stall        (pc_stall),
        .jump            (jump),
        .jump_target     (jump_target),
        .branch_taken    (branch_taken),
        .imm             (imm),
        .trapped         (trapped),
        .trap_target     (trap_target),
`ifdef PC_COMPRESSED_EN
        .inst_len16      (inst_len16),
`endif
        .pc              (pc),
        .next_pc         (next_pc),
        .pc_valid        (pc_valid),
        .pending_valid   (pending_valid),
        .misaligned      (misaligned),
        .misaligned_addr (misaligned_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: what the PC unit should hold after one clock edge.
    function automatic m_state_t model_next(input m_state_t s);
        m_state_t    n;
        int          prio;
        logic [31:0] tgt;
        logic [31:0] step;
        logic        bad;
        logic        usable;
        n    = s;
        step = 32'd4;
`ifdef PC_COMPRESSED_EN
        if (inst_len16) step = 32'd2;
`endif
        n.mis      = 1'b0;
        n.mis_addr = 32'h0;
        if (reset) begin
            n.pc    = RV;
            n.valid = 1'b0;
            n.pend  = 1'b0;
            n.pprio = 0;
            n.ptgt  = 32'h0;
            return n;
        end
        if (trapped) begin
            prio = 3;
            tgt  = trap_target & ~LOW_MASK;
        end else if (jump) begin
            prio = 2;
            tgt  = jump_target;
        end else if (branch_taken) begin
            prio = 1;
            tgt  = s.pc + imm;
        end else begin
            prio = 0;
            tgt  = 32'h0;
        end
        bad    = (prio == 1 || prio == 2) && ((tgt & LOW_MASK) != 32'h0);
        usable = (prio > 0) && (!s.pend || prio >= s.pprio);
        if (!s.valid) begin
            n.valid = 1'b1;
        end else if (pc_stall) begin
            if (usable && bad) begin
                n.mis      = 1'b1;
                n.mis_addr = tgt;
            end else if (usable) begin
                n.pend  = 1'b1;
                n.pprio = prio;
                n.ptgt  = tgt;
            end
        end else begin
            if (usable && bad) begin
                n.mis      = 1'b1;
                n.mis_addr = tgt;
            end else if (usable) begin
                n.pc = tgt;
            end else if (s.pend) begin
                n.pc = s.ptgt;
            end else begin
                n.pc = s.pc + step;
            end
            n.pend = 1'b0;
        end
        return n;
    endfunction

    // One clock: check next_pc before the edge, all registered outputs after.
    task automatic tick();
        m_state_t n;
        #1;
        n = model_next(m);
        check("next_pc", next_pc, n.pc);
        @(posedge clk);
        m = n;
        @(negedge clk);
        check("pc", pc, m.pc);
        check("pc_valid", 32'(pc_valid), 32'(m.valid));
        check("pending_valid", 32'(pending_valid), 32'(m.pend));
        check("misaligned", 32'(misaligned), 32'(m.mis));
        check("misaligned_addr", misaligned_addr, m.mis_addr);
    endtask

    task automatic idle();
        reset        = 1'b0;
        pc_stall     = 1'b0;
        trapped      = 1'b0;
        trap_target  = 32'h0;
        jump         = 1'b0;
        jump_target  = 32'h0;
        branch_taken = 1'b0;
        imm          = 32'h0;
`ifdef PC_COMPRESSED_EN
        inst_len16   = 1'b0;
`endif
    endtask

    task automatic step_in(input logic st, input logic tr, input logic [31:0] tt,
                           input logic j, input logic [31:0] jt,
                           input logic br, input logic [31:0] im);
        idle();
        pc_stall     = st;
        trapped      = tr;
        trap_target  = tt;
        jump         = j;
        jump_target  = jt;
        branch_taken = br;
        imm          = im;
        tick();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        tick();
        tick();
        check("reset_pc", pc, RV);
        check("reset_valid", 32'(pc_valid), 32'h0);

        // Release: one BOOT cycle with pc held, then +4 per cycle.
        idle();
        tick();
        check("boot_pc_hold", pc, RV);
        check("boot_valid_up", 32'(pc_valid), 32'h1);
        tick();
        tick();
        check("seq_step", pc, RV + 32'd8);

        // All redirect sources at once: trap wins.
        step_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0);
        check("jump_to_100", pc, 32'h100);
        step_in(1'b0, 1'b1, 32'h800, 1'b1, 32'h3000, 1'b1, 32'h40);
        check("trap_priority", pc, 32'h800);

        // Stall 3 cycles: branch then jump captured; jump applies on release.
        step_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40);
        step_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h2000, 1'b0, 32'h0);
        step_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stall_hold_pc", pc, 32'h800);
        check("stall_pending", 32'(pending_valid), 32'h1);
        step_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("release_jump", pc, 32'h2000);
        check("release_clear", 32'(pending_valid), 32'h0);

        // Release with a lower-priority redirect: pending jump still applies.
        step_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h3000, 1'b0, 32'h0);
        step_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h10);
        check("release_low_prio", pc, 32'h3000);
        // Release with a trap: trap overrides pending branch; low bits forced.
        step_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100);
        step_in(1'b0, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 32'h0);
        check("release_trap", pc, 32'h900);

        // Misaligned jump target.
        step_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h1002, 1'b0, 32'h0);
`ifdef PC_COMPRESSED_EN
        check("jump_1002_ok", pc, 32'h1002);
        check("jump_1002_nomis", 32'(misaligned), 32'h0);
`else
        check("misalign_pc_hold", pc, 32'h900);
        check("misalign_pulse", 32'(misaligned), 32'h1);
        check("misalign_addr", misaligned_addr, 32'h1002);
        step_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("misalign_one_cycle", 32'(misaligned), 32'h0);
`endif
        // Misaligned branch captured during stall is not stored.
        step_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h5);
        check("stall_misalign_nocap", 32'(pending_valid), 32'h0);

        // Wrap-around.
        step_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        step_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("wrap_to_zero", pc, 32'h0);

        // Reset while in HOLD discards the pending redirect.
        step_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h4000, 1'b0, 32'h0);
        check("hold_pending", 32'(pending_valid), 32'h1);
        idle();
        reset    = 1'b1;
        pc_stall = 1'b1;
        tick();
        check("reset_in_hold_pend", 32'(pending_valid), 32'h0);
        check("reset_in_hold_pc", pc, RV);
        idle();
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(99) == 0);
            pc_stall     = ($urandom_range(2) == 0);
            trapped      = ($urandom_range(7) == 0);
            jump         = ($urandom_range(4) == 0);
            branch_taken = ($urandom_range(4) == 0);
            jump_target  = $urandom;
            if ($urandom_range(5) != 0) jump_target[1:0] = 2'b00;
            imm          = $urandom;
            if ($urandom_range(5) != 0) imm[1:0] = 2'b00;
            trap_target  = $urandom;
`ifdef PC_COMPRESSED_EN
            inst_len16   = $urandom_range(1) == 1;
`endif
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
